// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / instruction-fetch stage: FSM encoding,
// instruction field positions and the sequential PC increment.
package pc_fetch_unit_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } fetch_state_e;

  localparam int OFFSET_MSB = 23;
  localparam int OFFSET_LSB = 16;
  localparam int PC_INCR    = 4;

endpackage

// File: rtl/pc_fetch_unit_branch_target_adder.sv
// Branch/jump target: PC+4 plus the sign-extended word offset scaled to bytes.
module branch_target_adder #(
  parameter int PC_WIDTH     = 32,
  parameter int OFFSET_WIDTH = 8
) (
  input  logic [PC_WIDTH-1:0]     pc4_i,
  input  logic [OFFSET_WIDTH-1:0] offset_i,
  output logic [PC_WIDTH-1:0]     target_o
);

  logic [PC_WIDTH-1:0] offset_ext;

  assign offset_ext = {{(PC_WIDTH-OFFSET_WIDTH){offset_i[OFFSET_WIDTH-1]}}, offset_i};
  // Word offset -> byte offset; the add wraps modulo 2^PC_WIDTH.
  assign target_o   = pc4_i + {offset_ext[PC_WIDTH-3:0], 2'b00};

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, next-PC selection and instruction register, sequenced by a
// two-state FETCH/EXEC machine with imem and dmem busywait handshakes.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  INSTR_WIDTH  = 32,
  parameter int                  OFFSET_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   J,
  input  logic                   BEQ,
  input  logic                   BNEQ,
  input  logic                   ZERO,
  input  logic                   DMEM_BUSYWAIT,
  input  logic                   IMEM_BUSYWAIT,
  input  logic [INSTR_WIDTH-1:0] IMEM_RDATA,
  output logic                   IMEM_READ,
  output logic [PC_WIDTH-1:0]    IMEM_ADDR,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [INSTR_WIDTH-1:0] INSTRUCTION,
  output logic                   INSTR_VALID
);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;

  logic [PC_WIDTH-1:0]    pc4;
  logic [PC_WIDTH-1:0]    target;
  logic [PC_WIDTH-1:0]    next_pc;
  logic                   taken;

  assign pc4     = pc_q + PC_WIDTH'(PC_INCR);
  assign taken   = J | (BEQ & ZERO) | (BNEQ & ~ZERO);
  assign next_pc = taken ? target : pc4;

  branch_target_adder #(
    .PC_WIDTH    (PC_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_target (
    .pc4_i   (pc4),
    .offset_i(instr_q[OFFSET_MSB:OFFSET_LSB]),
    .target_o(target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_FETCH: begin
        if (!IMEM_BUSYWAIT) begin
          instr_d = IMEM_RDATA;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!DMEM_BUSYWAIT) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Handshake outputs come from the state register; RESET only masks them.
  assign IMEM_READ   = (state_q == ST_FETCH) & ~RESET;
  assign INSTR_VALID = (state_q == ST_EXEC) & ~RESET;
  assign IMEM_ADDR   = pc_q;
  assign PC          = pc_q;
  assign INSTRUCTION = instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized
// run, all compared against a cycle-level reference model of the fetch stage.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        J = 1'b0, BEQ = 1'b0, BNEQ = 1'b0, ZERO = 1'b0;
  logic        DMEM_BUSYWAIT = 1'b0, IMEM_BUSYWAIT = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        IMEM_READ, INSTR_VALID;
  logic [31:0] IMEM_ADDR, PC, INSTRUCTION;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: current PC, instruction register, and whether an
  // instruction is currently executing.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ir = 32'h0;
  bit          m_exec = 1'b0;

  wire [97:0] obs = {PC, INSTRUCTION, IMEM_READ, INSTR_VALID, IMEM_ADDR};

  pc_fetch_unit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .J            (J),
    .BEQ          (BEQ),
    .BNEQ         (BNEQ),
    .ZERO         (ZERO),
    .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .IMEM_RDATA   (IMEM_RDATA),
    .IMEM_READ    (IMEM_READ),
    .IMEM_ADDR    (IMEM_ADDR),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .INSTR_VALID  (INSTR_VALID)
  );

  always #5 CLK = ~CLK;

  function automatic logic [97:0] exp_vec();
    logic rd, vld;
    rd  = !m_exec && !RESET;
    vld = m_exec && !RESET;
    return {m_pc, m_ir, rd, vld, m_pc};
  endfunction

  // One clock edge: the model consumes the inputs present at the edge, then
  // outputs are sampled 1 time unit later by the callers.
  task automatic tick();
    @(posedge CLK);
    if (RESET) begin
      m_pc   = 32'h0;
      m_ir   = 32'h0;
      m_exec = 1'b0;
    end else if (!m_exec) begin
      if (!IMEM_BUSYWAIT) begin
        m_ir   = IMEM_RDATA;
        m_exec = 1'b1;
      end
    end else if (!DMEM_BUSYWAIT) begin
      bit tk;
      int off;
      tk  = J || (BEQ && ZERO) || (BNEQ && !ZERO);
      off = $signed(m_ir[23:16]);
      m_pc   = tk ? m_pc + 32'd4 + 32'(off * 4) : m_pc + 32'd4;
      m_exec = 1'b0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    RESET = 1'b0; J = 1'b0; BEQ = 1'b0; BNEQ = 1'b0; ZERO = 1'b0;
    DMEM_BUSYWAIT = 1'b0; IMEM_BUSYWAIT = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  // Fetch one instruction carrying the given offset, then execute it with the
  // given control-unit and ALU flags.
  task automatic exec_instr(input logic [7:0] off, input bit j, input bit beq,
                            input bit bneq, input bit zero);
    clear_inputs();
    IMEM_RDATA = {8'($urandom), off, 16'($urandom)};
    tick();
    J = j; BEQ = beq; BNEQ = bneq; ZERO = zero;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    RESET = 1'b1;
    IMEM_BUSYWAIT = 1'($urandom);
    IMEM_RDATA = $urandom;
    tick();
    tick();
    n_total++;
    if (obs !== exp_vec()) $display("FAIL reset_model: got %h want %h", obs, exp_vec());
    else n_pass++;
    n_total++;
    if ({PC, INSTRUCTION, IMEM_READ, INSTR_VALID} !== 66'h0)
      $display("FAIL reset_state: got pc=%h ir=%h rd=%b vld=%b want all zero",
               PC, INSTRUCTION, IMEM_READ, INSTR_VALID);
    else n_pass++;
    RESET = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    #1;
    n_total++;
    if ({IMEM_READ, INSTR_VALID} !== 2'b10)
      $display("FAIL reset_release: got rd/vld=%b%b want 10", IMEM_READ, INSTR_VALID);
    else n_pass++;
  endtask

  task automatic test_sequential();
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      IMEM_RDATA = $urandom;
      tick();
      n_total++;
      if (obs !== exp_vec()) $display("FAIL seq_cycle%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_total++;
    if ({PC, IMEM_READ, INSTR_VALID} !== {32'd12, 2'b10})
      $display("FAIL seq_pc12: got pc=%0d rd/vld=%b%b want pc=12 rd/vld=10",
               PC, IMEM_READ, INSTR_VALID);
    else n_pass++;
  endtask

  task automatic test_imem_busywait();
    logic [31:0] word;
    do_reset();
    exec_instr(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    exec_instr(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    word = $urandom;
    IMEM_RDATA = word;
    IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({IMEM_ADDR, IMEM_READ, INSTR_VALID} !== {32'd8, 2'b10} || obs !== exp_vec())
        $display("FAIL ibw_hold%0d: got addr=%0d rd/vld=%b%b want addr=8 rd/vld=10",
                 i, IMEM_ADDR, IMEM_READ, INSTR_VALID);
      else n_pass++;
    end
    IMEM_BUSYWAIT = 1'b0;
    tick();
    n_total++;
    if ({INSTRUCTION, INSTR_VALID, PC} !== {word, 1'b1, 32'd8})
      $display("FAIL ibw_latch: got ir=%h vld=%b pc=%0d want ir=%h vld=1 pc=8",
               INSTRUCTION, INSTR_VALID, PC, word);
    else n_pass++;
  endtask

  task automatic test_jump();
    do_reset();
    exec_instr(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (PC !== 32'd16) $display("FAIL jump_to16: got %0d want 16", PC);
    else n_pass++;
    exec_instr(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (PC !== 32'd28) $display("FAIL jump_fwd: got %0d want 28", PC);
    else n_pass++;
    do_reset();
    exec_instr(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    exec_instr(8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (PC !== 32'd12) $display("FAIL jump_back: got %0d want 12", PC);
    else n_pass++;
    // Several taken terms at once still select the single target.
    do_reset();
    exec_instr(8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
    n_total++;
    if (PC !== 32'd16) $display("FAIL jump_multi: got %0d want 16", PC);
    else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    exec_instr(8'h03, 1'b0, 1'b1, 1'b0, 1'b1);
    n_total++;
    if (PC !== 32'd16) $display("FAIL beq_taken: got %0d want 16", PC);
    else n_pass++;
    do_reset();
    exec_instr(8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (PC !== 32'd4) $display("FAIL beq_not: got %0d want 4", PC);
    else n_pass++;
    do_reset();
    exec_instr(8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    n_total++;
    if (PC !== 32'd16) $display("FAIL bneq_taken: got %0d want 16", PC);
    else n_pass++;
    do_reset();
    exec_instr(8'h03, 1'b0, 1'b0, 1'b1, 1'b1);
    n_total++;
    if (PC !== 32'd4) $display("FAIL bneq_not: got %0d want 4", PC);
    else n_pass++;
  endtask

  task automatic test_dmem_busywait();
    logic [31:0] word;
    do_reset();
    word = {8'hA5, 8'h05, 16'($urandom)};
    IMEM_RDATA = word;
    DMEM_BUSYWAIT = 1'b1;  // must not block a fetch
    tick();
    n_total++;
    if ({INSTR_VALID, INSTRUCTION} !== {1'b1, word})
      $display("FAIL dbw_in_fetch: got vld=%b ir=%h want vld=1 ir=%h", INSTR_VALID, INSTRUCTION, word);
    else n_pass++;
    J = 1'b1;
    IMEM_BUSYWAIT = 1'b1;  // must not block leaving EXEC
    IMEM_RDATA = $urandom;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if ({PC, INSTRUCTION, INSTR_VALID, IMEM_READ} !== {32'd0, word, 2'b10})
        $display("FAIL dbw_hold%0d: got pc=%0d ir=%h vld/rd=%b%b want pc=0 ir=%h vld/rd=10",
                 i, PC, INSTRUCTION, INSTR_VALID, IMEM_READ, word);
      else n_pass++;
    end
    DMEM_BUSYWAIT = 1'b0;
    tick();
    n_total++;
    if ({PC, INSTR_VALID, IMEM_READ} !== {32'd24, 2'b01})
      $display("FAIL dbw_release: got pc=%0d vld/rd=%b%b want pc=24 vld/rd=01",
               PC, INSTR_VALID, IMEM_READ);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    exec_instr(8'h09, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (PC !== 32'd40) $display("FAIL reach40: got %0d want 40", PC);
    else n_pass++;
    IMEM_BUSYWAIT = 1'b1;
    tick();
    RESET = 1'b1;
    tick();
    n_total++;
    if ({PC, INSTRUCTION, IMEM_READ, INSTR_VALID} !== 66'h0)
      $display("FAIL reset_mid: got pc=%0d ir=%h rd/vld=%b%b want 0 0 00",
               PC, INSTRUCTION, IMEM_READ, INSTR_VALID);
    else n_pass++;
    clear_inputs();
    #1;
    n_total++;
    if ({IMEM_READ, INSTR_VALID, IMEM_ADDR} !== {2'b10, 32'd0})
      $display("FAIL reset_mid_fetch: got rd/vld=%b%b addr=%0d want 10 addr=0",
               IMEM_READ, INSTR_VALID, IMEM_ADDR);
    else n_pass++;
  endtask

  task automatic test_wrap_and_loop();
    do_reset();
    exec_instr(8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (PC !== 32'hFFFF_FFFC) $display("FAIL wrap_neg: got %h want fffffffc", PC);
    else n_pass++;
    exec_instr(8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (PC !== 32'h0) $display("FAIL wrap_pc4: got %h want 00000000", PC);
    else n_pass++;
    exec_instr(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
    n_total++;
    if (PC !== 32'h0) $display("FAIL self_loop: got %h want 00000000", PC);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RESET         = ($urandom_range(0, 39) == 0);
      IMEM_BUSYWAIT = ($urandom_range(0, 2) == 0);
      DMEM_BUSYWAIT = ($urandom_range(0, 2) == 0);
      J             = ($urandom_range(0, 3) == 0);
      BEQ           = ($urandom_range(0, 2) == 0);
      BNEQ          = ($urandom_range(0, 2) == 0);
      ZERO          = 1'($urandom);
      IMEM_RDATA    = $urandom;
      tick();
      n_total++;
      if (obs !== exp_vec()) $display("FAIL rand_cycle%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_imem_busywait();
    test_jump();
    test_branch();
    test_dmem_busywait();
    test_reset_midfetch();
    test_wrap_and_loop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
